// File: rtl/voice_mixer_if.sv
// ============================================================================
//  Module      : voice_mixer_if
//  Description : Request/result bundle between the note-player bank and the
//                voice mixer. The master drives requests and voice data; the
//                slave (the mixer) returns the mixed sample and status.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface voice_mixer_if #(
    parameter int VOICES = 3,
    parameter int WIDTH  = 16
);
    logic                      start;
    logic [VOICES*WIDTH-1:0]   voice_samples;
    logic [VOICES-1:0]         voice_active;
    logic                      busy;
    logic [WIDTH-1:0]          mix_sample;
    logic                      mix_valid;
    logic                      clip;
    logic                      overrun;

    modport master (
        output start,
        output voice_samples,
        output voice_active,
        input  busy,
        input  mix_sample,
        input  mix_valid,
        input  clip,
        input  overrun
    );

    modport slave (
        input  start,
        input  voice_samples,
        input  voice_active,
        output busy,
        output mix_sample,
        output mix_valid,
        output clip,
        output overrun
    );
endinterface

`default_nettype wire

// File: rtl/voice_mixer.sv
// ============================================================================
//  Module      : voice_mixer
//  Description : Time-multiplexed mixer. Sums VOICES signed, pre-shifted and
//                maskable voice samples one per cycle into a wide accumulator,
//                then emits a WIDTH-bit result with a one-cycle mix_valid.
//                A one-deep pending flag queues a request that arrives while
//                a mix is in progress; a second one is dropped with overrun.
//                Optional feature macro: VOICE_MIXER_SATURATE_EN selects
//                clamping (with clip flag) instead of two's-complement wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module voice_mixer #(
    parameter int VOICES = 3,
    parameter int WIDTH  = 16,
    parameter int SHIFT  = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    voice_mixer_if.slave     bus
);

    // Headroom for the sum of VOICES full-scale terms plus sign.
    localparam int ACC_W = WIDTH + $clog2(VOICES) + 1;
    localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;

    logic [VOICES*WIDTH-1:0]    r_samples;
    logic [VOICES-1:0]          r_active;
    logic signed [ACC_W-1:0]    r_acc;
    logic [IDX_W-1:0]           r_idx;
    logic                       r_pending;
    logic [WIDTH-1:0]           r_mix_sample;
    logic                       r_mix_valid;
    logic                       r_overrun;

    logic                       w_capture;
    logic                       w_acc_add;
    logic                       w_out_load;
    logic                       w_set_pending;
    logic                       w_clr_pending;
    logic                       w_overrun_next;
    logic [WIDTH-1:0]           w_resolved;

    logic signed [ACC_W-1:0]    w_terms [VOICES];

    // Per-voice term from the captured copy: sign-extend, scale, mask.
    for (genvar gi = 0; gi < VOICES; gi++) begin : g_term
        logic signed [ACC_W-1:0] w_ext;
        assign w_ext       = ACC_W'(signed'(r_samples[gi*WIDTH +: WIDTH]));
        assign w_terms[gi] = r_active[gi] ? (w_ext >>> SHIFT) : '0;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode, including the one-deep request queue.
    always_comb begin
        w_state_next   = r_state;
        w_capture      = 1'b0;
        w_acc_add      = 1'b0;
        w_out_load     = 1'b0;
        w_set_pending  = 1'b0;
        w_clr_pending  = 1'b0;
        w_overrun_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_capture    = 1'b1;
                    w_state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_acc_add = 1'b1;
                if (bus.start) begin
                    if (r_pending) begin
                        w_overrun_next = 1'b1;
                    end else begin
                        w_set_pending = 1'b1;
                    end
                end
                if (r_idx == LAST_IDX) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                w_out_load = 1'b1;
                // A start in this cycle is folded into the recapture, so it
                // never needs the pending flag.
                if (r_pending || bus.start) begin
                    w_capture     = 1'b1;
                    w_clr_pending = 1'b1;
                    w_state_next  = S_ACCUM;
                end else begin
                    w_state_next  = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Input capture, accumulator and voice index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_samples <= '0;
            r_active  <= '0;
            r_acc     <= '0;
            r_idx     <= '0;
        end else if (w_capture) begin
            r_samples <= bus.voice_samples;
            r_active  <= bus.voice_active;
            r_acc     <= '0;
            r_idx     <= '0;
        end else if (w_acc_add) begin
            r_acc     <= r_acc + w_terms[r_idx];
            r_idx     <= r_idx + IDX_W'(1);
        end
    end

    // Pending request flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else if (w_clr_pending) begin
            r_pending <= 1'b0;
        end else if (w_set_pending) begin
            r_pending <= 1'b1;
        end
    end

    // Registered result, valid strobe and overrun strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mix_sample <= '0;
            r_mix_valid  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_mix_valid <= w_out_load;
            r_overrun   <= w_overrun_next;
            if (w_out_load) begin
                r_mix_sample <= w_resolved;
            end
        end
    end

`ifdef VOICE_MIXER_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic w_clamped;
    logic r_clip;

    // Clamp the accumulator into the WIDTH-bit signed range.
    always_comb begin
        w_resolved = r_acc[WIDTH-1:0];
        w_clamped  = 1'b0;
        if (r_acc > SAT_MAX) begin
            w_resolved = SAT_MAX[WIDTH-1:0];
            w_clamped  = 1'b1;
        end else if (r_acc < SAT_MIN) begin
            w_resolved = SAT_MIN[WIDTH-1:0];
            w_clamped  = 1'b1;
        end
    end

    // Clip flag follows each result and holds with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clip <= 1'b0;
        end else if (w_out_load) begin
            r_clip <= w_clamped;
        end
    end

    assign bus.clip = r_clip;
`else
    // Wrap mode: the guard bits above WIDTH are intentionally discarded.
    logic w_unused_acc_hi;
    assign w_unused_acc_hi = ^r_acc[ACC_W-1:WIDTH];
    assign w_resolved      = r_acc[WIDTH-1:0];
    assign bus.clip        = 1'b0;
`endif

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.mix_sample = r_mix_sample;
    assign bus.mix_valid  = r_mix_valid;
    assign bus.overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_voice_mixer.sv
// ============================================================================
//  Module      : tb_voice_mixer
//  Description : Directed bench for voice_mixer. dut_a uses SHIFT=2 for the
//                sum, masking, queueing and reset cases; dut_b uses SHIFT=0
//                for the positive and negative overflow cases.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_voice_mixer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    voice_mixer_if #(.VOICES(3), .WIDTH(16)) ifa ();
    voice_mixer_if #(.VOICES(3), .WIDTH(16)) ifb ();

    voice_mixer #(.VOICES(3), .WIDTH(16), .SHIFT(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    voice_mixer #(.VOICES(3), .WIDTH(16), .SHIFT(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        ifa.start = 1'b0; ifa.voice_samples = '0; ifa.voice_active = '0;
        ifb.start = 1'b0; ifb.voice_samples = '0; ifb.voice_active = '0;
        tick();
        tick();
        check("rst_busy",    32'(ifa.busy),       32'h0);
        check("rst_sample",  32'(ifa.mix_sample), 32'h0);
        check("rst_valid",   32'(ifa.mix_valid),  32'h0);
        check("rst_clip",    32'(ifa.clip),       32'h0);
        check("rst_overrun", 32'(ifa.overrun),    32'h0);
        reset = 1'b0;
        tick();

        // Basic sum: 3 x (0x4000 >>> 2) = 0x3000, valid only in cycle 5.
        ifa.voice_samples = {16'h4000, 16'h4000, 16'h4000};
        ifa.voice_active  = 3'b111;
        ifa.start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) begin
                ifa.start = 1'b0;
                // Changing inputs during accumulation must not matter.
                ifa.voice_samples = {16'h1234, 16'h8000, 16'h7FFF};
                ifa.voice_active  = 3'b010;
            end
            check($sformatf("sum_valid_c%0d", c), 32'(ifa.mix_valid), 32'((c == 5) ? 1 : 0));
            if (c == 1) check("sum_busy_c1", 32'(ifa.busy), 32'h1);
            if (c == 4) check("sum_busy_c4", 32'(ifa.busy), 32'h1);
            if (c == 5) begin
                check("sum_busy_c5",  32'(ifa.busy),       32'h0);
                check("sum_sample",   32'(ifa.mix_sample), 32'h3000);
                check("sum_clip",     32'(ifa.clip),       32'h0);
            end
        end
        check("sum_hold", 32'(ifa.mix_sample), 32'h3000);

        // Masking: 0x4000>>>2 + (voice1 off) + 0x7FFC>>>2 = 0x1000 + 0x1FFF.
        ifa.voice_samples = {16'h7FFC, 16'h2000, 16'h4000};
        ifa.voice_active  = 3'b101;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tick(); tick(); tick(); tick();
        check("mask_valid",  32'(ifa.mix_valid),  32'h1);
        check("mask_sample", 32'(ifa.mix_sample), 32'h2FFF);
        tick(); tick();

        // Queueing: starts in cycles 0, 2, 3 -> valid in 5 and 9, overrun in 4.
        ifa.start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            check($sformatf("q_valid_c%0d", c),   32'(ifa.mix_valid), 32'((c == 5 || c == 9) ? 1 : 0));
            check($sformatf("q_overrun_c%0d", c), 32'(ifa.overrun),   32'((c == 4) ? 1 : 0));
            if (c == 9)  check("q_sample_c9", 32'(ifa.mix_sample), 32'h2FFF);
            if (c == 10) check("q_busy_c10",  32'(ifa.busy),       32'h0);
            ifa.start = (c == 2 || c == 3);
        end

        // Reset mid-mix: start in cycle 0, reset during cycle 2.
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("rm_busy",   32'(ifa.busy),       32'h0);
        check("rm_sample", 32'(ifa.mix_sample), 32'h0);
        check("rm_valid",  32'(ifa.mix_valid),  32'h0);
        tick();
        reset = 1'b0;
        for (int c = 3; c <= 17; c++) begin
            check($sformatf("rm_valid_c%0d", c), 32'(ifa.mix_valid), 32'((c == 15) ? 1 : 0));
            if (c == 15) check("rm_sample_c15", 32'(ifa.mix_sample), 32'h2FFF);
            ifa.start = (c == 10);
            tick();
        end

        // Positive overflow on dut_b (SHIFT=0): 3 x 0x7FFF.
        ifb.voice_samples = {16'h7FFF, 16'h7FFF, 16'h7FFF};
        ifb.voice_active  = 3'b111;
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        tick(); tick(); tick(); tick();
        check("pos_valid", 32'(ifb.mix_valid), 32'h1);
`ifdef VOICE_MIXER_SATURATE_EN
        check("pos_sample", 32'(ifb.mix_sample), 32'h7FFF);
        check("pos_clip",   32'(ifb.clip),       32'h1);
`else
        check("pos_sample", 32'(ifb.mix_sample), 32'h7FFD);
        check("pos_clip",   32'(ifb.clip),       32'h0);
`endif
        tick(); tick();

        // Negative overflow on dut_b: 3 x 0xC000.
        ifb.voice_samples = {16'hC000, 16'hC000, 16'hC000};
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        tick(); tick(); tick(); tick();
        check("neg_valid", 32'(ifb.mix_valid), 32'h1);
`ifdef VOICE_MIXER_SATURATE_EN
        check("neg_sample", 32'(ifb.mix_sample), 32'h8000);
        check("neg_clip",   32'(ifb.clip),       32'h1);
`else
        check("neg_sample", 32'(ifb.mix_sample), 32'h4000);
        check("neg_clip",   32'(ifb.clip),       32'h0);
`endif
        tick();
        check("neg_valid_drop", 32'(ifb.mix_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/voice_mixer.md
# voice_mixer

Parametrised, time-multiplexed mixer that combines VOICES signed note-player samples into one codec sample. It sits between a bank of note_player instances and codec_conditioner, replacing fixed three-voice combinational summing. It adds per-voice masking, a wide accumulator, optional saturation, and a one-deep request queue.

## Interface
- VOICES, 3: number of voice inputs (1..16)
- WIDTH, 16: sample width in bits, signed two's complement
- SHIFT, 2: arithmetic right shift applied to each voice before summing (0..WIDTH-1)
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  request a new mix; normally the OR of the note players' new_sample_ready
- voice_samples  input  VOICES*WIDTH  packed samples; voice i occupies bits [i*WIDTH +: WIDTH]
- voice_active  input  VOICES  per-voice enable; a 0 contributes 0 to the mix
- busy  output  1  high whenever state is not IDLE
- mix_sample  output  WIDTH  mixed result; holds until the next result
- mix_valid  output  1  one-cycle pulse when mix_sample updates
- clip  output  1  sticky per result: high with mix_valid's sample if it was clamped
- overrun  output  1  one-cycle pulse when a start request is dropped

## Operation
- Accumulator width ACC_W = WIDTH + clog2(VOICES) + 1, as a localparam.
- Term i = sign-extend(voice_samples[i]) to ACC_W, then >>> SHIFT, if voice_active[i]; otherwise 0.
- voice_samples and voice_active are captured into internal registers when a mix starts. Inputs may change during ACCUM without effect.
- State machine:
  - IDLE: on start, capture inputs, acc <= 0, idx <= 0, go to ACCUM.
  - ACCUM: acc <= acc + term[idx], idx <= idx + 1. When idx == VOICES-1, go to OUT.
  - OUT: mix_sample <= resolve(acc + 0), mix_valid <= 1, clip updated. If pending or start, recapture inputs, clear pending, go to ACCUM; otherwise go to IDLE.
- resolve() takes the low WIDTH bits of acc, or clamps acc when saturation is enabled; see Configuration.
- Request queue:
  - A start in ACCUM sets pending.
  - A start in ACCUM while pending is already set pulses overrun, and the request is dropped.
  - A start in OUT is serviced directly by the recapture and never sets pending.
- Reset values: state IDLE, acc 0, idx 0, pending 0, mix_sample 0, mix_valid 0, clip 0, overrun 0, busy 0, captured registers 0.

## Timing
- Count the cycle in which start is sampled high as cycle 0.
  - State is ACCUM in cycles 1..VOICES and OUT in cycle VOICES+1.
  - mix_valid is high in cycle VOICES+2 only. For VOICES=3 this is cycle 5.
- busy rises in cycle 1 and falls in cycle VOICES+2 if no follow-on request is pending.
- Back-to-back mixes: a serviced pending or OUT-cycle start yields mix_valid every VOICES+1 cycles.
- Throughput limit is one mix per VOICES+1 cycles. At 48 kHz frames this is far below the clock rate, so overrun indicates a misconfigured request source.
- Asserting reset mid-ACCUM:
  - Aborts the mix and produces no mix_valid.
  - mix_sample returns to 0 asynchronously.
  - The first start after deassertion behaves as from IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- VOICE_MIXER_SATURATE_EN defined:
  - resolve() clamps acc to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - clip is 1 for a result that was clamped and 0 otherwise.
- VOICE_MIXER_SATURATE_EN undefined:
  - resolve() keeps the low WIDTH bits (two's-complement wrap).
  - clip is tied to 0.
  - The clamp comparators are not synthesised.

## Test plan
- Basic sum (VOICES=3, WIDTH=16, SHIFT=2): all samples 0x4000, all voices active, start in cycle 0 -> mix_valid only in cycle 5, mix_sample 0x3000, clip 0.
- Masking (SHIFT=2): samples 0x4000/0x2000/0x7FFC with voice_active=3'b101 -> mix_sample 0x2FFF.
- Saturation (SHIFT=0): three voices of 0x7FFF -> 0x7FFF with clip=1 when the macro is defined, 0x7FFD with clip=0 when undefined.
- Negative saturation (SHIFT=0): three voices of 0xC000 -> 0x8000 with clip=1 when the macro is defined, 0x4000 when undefined.
- Queueing:
  - start in cycle 0, start again in cycle 2 -> mix_valid in cycles 5 and 9.
  - A third start in cycle 3 -> overrun pulse in cycle 4, and no third mix_valid.
- Reset mid-mix: start in cycle 0, reset pulsed in cycle 2 -> no mix_valid, and busy=0, mix_sample=0 while reset is high. Then start in cycle 10 -> mix_valid in cycle 15.
